clock_mode_controller: RTL and testbench
========================================

Name: clock_mode_controller

Overview:
- Sequencing controller for the six-digit HH:MM:SS digital clock counter chain.
- Owns run/pause/set mode and generates the single-cycle 1 Hz count-enable for the seconds counter.
- Converts the SW[9:4] switch value into clamped BCD load data with load strobes for the hours and minutes digit pairs.
- Drives a blink mask for the seven-segment drivers while a field is being set. Replaces clock gating with a clean clock-enable scheme.

Parameters:
- TICK_DIV, 50000000: CLK_50_MHZ_GEN cycles per 1 Hz tick. Minimum 2.
- BLINK_DIV, 12500000: cycles per blink-phase toggle. Minimum 2.

Ports:
- CLK_50_MHZ_GEN  input  1  system clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- Time_Stop  input  1  level: 1 = run, 0 = pause. Asynchronous to the clock; debounced upstream.
- Time_Set  input  1  set-advance button, active-high. Asynchronous; debounced upstream.
- SW  input  6 [9:4]  binary value for the field being set.
- tick_1hz  output  1  one-cycle count-enable to the seconds counter.
- load_hours  output  1  one-cycle strobe: load hours digits.
- load_minutes  output  1  one-cycle strobe: load minutes digits and clear seconds to 00.
- load_tens  output  4  BCD tens digit, valid while a strobe is high.
- load_ones  output  4  BCD ones digit, valid while a strobe is high.
- blink_mask  output  6  1 = blank that digit. Bit 5 = Hex5 … bit 0 = Hex0.
- mode  output  2  00 RUN, 01 PAUSED, 10 SET_HR, 11 SET_MIN.

Behaviour:
Reset values:
- Reset=1 asynchronously forces: state RUN; mode=00; all strobes 0; tick_1hz=0; load_tens/load_ones=0; blink_mask=0.
- Prescaler, blink counter and blink phase are cleared to 0.
- Synchronizer flops are cleared to 0.

Input synchronization:
- Time_Stop and Time_Set each pass through a 2-FF synchronizer.
- Time_Set also has a third flop for rising-edge detection.
- An input change sampled at clock edge k acts on state and outputs at edge k+2. All outputs are registered.

State machine (one transition per cycle):
- RUN:
  - set_edge -> SET_HR.
  - else stop_sync=0 -> PAUSED.
- PAUSED:
  - set_edge -> SET_HR.
  - else stop_sync=1 -> RUN.
- SET_HR:
  - set_edge -> SET_MIN.
  - In the same cycle, pulse load_hours with data = min(SW,23) split into BCD.
- SET_MIN:
  - set_edge -> RUN.
  - In the same cycle, pulse load_minutes with data = min(SW,59) split into BCD.
  - The prescaler is cleared to 0 on this transition.
- set_edge has priority over Time_Stop in every state.
- Time_Stop is ignored in SET_HR and SET_MIN.
- Exit from SET_MIN always goes to RUN. If Time_Stop=0 at that point, the next cycle moves to PAUSED.

BCD split:
- tens = v/10, ones = v%10, with v in 0..59 after clamping.
- Examples: 63 clamps to 23 (hours) or 59 (minutes); 7 -> 0,7.
- load_tens/load_ones hold their last value when no strobe is active.

Prescaler:
- Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSED, SET_HR and SET_MIN.
- tick_1hz=1 for exactly the cycle after the counter reaches TICK_DIV-1 in RUN; the counter wraps to 0.
- If the state leaves RUN on the wrap cycle, the tick is still suppressed, because the registered output uses the next state.

Blink:
- The blink counter runs in all states.
- Every BLINK_DIV cycles, blink_phase toggles.
- blink_mask = 110000 in SET_HR when phase=1; 001100 in SET_MIN when phase=1; 000000 otherwise.

Simultaneous events and mid-operation reset:
- Reset mid-set discards the pending field; no strobe is issued.
- Strobes are never issued together. At most one of tick_1hz, load_hours, load_minutes is high in any cycle.

Test Plan:
1. Reset, then Time_Stop=1, TICK_DIV=10 -> tick_1hz pulses every 10 cycles, single cycle, mode=00.
2. Time_Stop drops to 0 mid-count (prescaler=6) -> mode=01 two edges later, no ticks. Restore Time_Stop=1 -> first tick 4 cycles after RUN resumes.
3. Time_Set pulse, SW=14, Time_Set pulse, SW=37, Time_Set pulse -> load_hours with tens=1/ones=4, then load_minutes with tens=3/ones=7, mode returns 00. The next tick arrives a full TICK_DIV after exit.
4. Hours set with SW=63 -> load_hours, tens=2, ones=3. Minutes set with SW=60 -> tens=5, ones=9.
5. In SET_HR with BLINK_DIV=4 -> blink_mask alternates 110000/000000 every 4 cycles. In SET_MIN it alternates 001100/000000. In RUN it stays 000000.
6. Assert Reset while in SET_MIN -> mode=00 immediately, with no load_minutes strobe. Time_Set edge and Time_Stop fall in the same cycle in RUN -> next state SET_HR.

Source files
------------

// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - run/pause/set sequencer for the HH:MM:SS counter chain
// Produces the 1 Hz count-enable, clamped BCD load strobes and the set-mode blink mask.
module clock_mode_controller #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       CLK_50_MHZ_GEN,
  input  logic       Reset,
  input  logic       Time_Stop,
  input  logic       Time_Set,
  input  logic [9:4] SW,
  output logic       tick_1hz,
  output logic       load_hours,
  output logic       load_minutes,
  output logic [3:0] load_tens,
  output logic [3:0] load_ones,
  output logic [5:0] blink_mask,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_PAUSED  = 2'b01,
    S_SET_HR  = 2'b10,
    S_SET_MIN = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          tick_q, tick_d;
  logic          lh_q, lh_d;
  logic          lm_q, lm_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [5:0]    mask_q, mask_d;
  logic          stop_s1_q, stop_s2_q;
  logic          set_s1_q, set_s2_q, set_s3_q;

  logic          set_edge;
  logic [5:0]    hr_v, min_v;
  logic [7:0]    hr_bcd, min_bcd;

  // Inputs are at most 59 here, so the ones digit fits in 4 bits and mod-16 arithmetic is exact.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    if (v >= 6'd50)      t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    return {t, v[3:0] - 4'(t * 4'd10)};
  endfunction

  assign set_edge = set_s2_q & ~set_s3_q;
  assign hr_v     = (SW > 6'd23) ? 6'd23 : SW;
  assign min_v    = (SW > 6'd59) ? 6'd59 : SW;
  assign hr_bcd   = to_bcd(hr_v);
  assign min_bcd  = to_bcd(min_v);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    lh_d    = 1'b0;
    lm_d    = 1'b0;
    tens_d  = tens_q;
    ones_d  = ones_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    mask_d  = 6'b000000;

    case (state_q)
      S_RUN: begin
        if (set_edge)        state_d = S_SET_HR;
        else if (!stop_s2_q) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (set_edge)       state_d = S_SET_HR;
        else if (stop_s2_q) state_d = S_RUN;
      end
      S_SET_HR: begin
        if (set_edge) begin
          state_d          = S_SET_MIN;
          lh_d             = 1'b1;
          {tens_d, ones_d} = hr_bcd;
        end
      end
      S_SET_MIN: begin
        if (set_edge) begin
          state_d          = S_RUN;
          lm_d             = 1'b1;
          {tens_d, ones_d} = min_bcd;
          presc_d          = '0;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Tick is qualified by the next state so a wrap on the way out of RUN stays silent.
    if (state_q == S_RUN) begin
      if (presc_q == TW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = (state_d == S_RUN);
      end else begin
        presc_d = presc_q + TW'(1);
      end
    end

    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end

    if (phase_d) begin
      if (state_d == S_SET_HR)       mask_d = 6'b110000;
      else if (state_d == S_SET_MIN) mask_d = 6'b001100;
    end
  end

  always_ff @(posedge CLK_50_MHZ_GEN or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_RUN;
      presc_q   <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      tick_q    <= 1'b0;
      lh_q      <= 1'b0;
      lm_q      <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      mask_q    <= 6'b000000;
      stop_s1_q <= 1'b0;
      stop_s2_q <= 1'b0;
      set_s1_q  <= 1'b0;
      set_s2_q  <= 1'b0;
      set_s3_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      lh_q      <= lh_d;
      lm_q      <= lm_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      mask_q    <= mask_d;
      stop_s1_q <= Time_Stop;
      stop_s2_q <= stop_s1_q;
      set_s1_q  <= Time_Set;
      set_s2_q  <= set_s1_q;
      set_s3_q  <= set_s2_q;
    end
  end

  assign tick_1hz     = tick_q;
  assign load_hours   = lh_q;
  assign load_minutes = lm_q;
  assign load_tens    = tens_q;
  assign load_ones    = ones_q;
  assign blink_mask   = mask_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// tb/tb_clock_mode_controller.sv - directed self-checking bench for clock_mode_controller
module tb_clock_mode_controller;

  logic       clk;
  logic       rst;
  logic       time_stop;
  logic       time_set;
  logic [5:0] sw;
  logic       tick;
  logic       lh;
  logic       lm;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [5:0] mask;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  clock_mode_controller #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
    .CLK_50_MHZ_GEN(clk),
    .Reset(rst),
    .Time_Stop(time_stop),
    .Time_Set(time_set),
    .SW(sw),
    .tick_1hz(tick),
    .load_hours(lh),
    .load_minutes(lm),
    .load_tens(tens),
    .load_ones(ones),
    .blink_mask(mask),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge and strobe exclusivity is checked every cycle.
  task automatic cyc();
    @(negedge clk);
    check("strobe_onehot", 8'({tick, lh, lm} inside {3'b000, 3'b100, 3'b010, 3'b001}), 8'h01);
  endtask

  task automatic set_pulse();
    time_set = 1'b1;
    cyc();
    cyc();
    time_set = 1'b0;
    cyc();
  endtask

  task automatic wait_tick(output int n, input int budget);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < budget);
  endtask

  task automatic check_blink(input string tag, input logic [5:0] on_pat);
    logic [5:0] prev;
    logic [5:0] v0;
    int         k;
    cyc();
    prev = mask;
    k = 0;
    do begin
      cyc();
      k++;
    end while (mask === prev && k < 10);
    v0 = mask;
    check({tag, "_level"}, 8'((v0 === on_pat) || (v0 === 6'b000000)), 8'h01);
    for (int i = 1; i < 12; i++) begin
      cyc();
      check({tag, "_seq"}, 8'(mask), 8'(((i / 4) % 2 == 0) ? v0 : (v0 ^ on_pat)));
    end
  endtask

  initial begin
    int         n;
    logic [5:0] acc;
    rst       = 1'b1;
    time_stop = 1'b1;
    time_set  = 1'b0;
    sw        = 6'd0;
    cyc();
    cyc();
    check("rst_mode", 8'(mode), 8'h00);
    check("rst_tick", 8'(tick), 8'h00);
    check("rst_lh",   8'(lh),   8'h00);
    check("rst_lm",   8'(lm),   8'h00);
    check("rst_tens", 8'(tens), 8'h00);
    check("rst_ones", 8'(ones), 8'h00);
    check("rst_mask", 8'(mask), 8'h00);
    rst = 1'b0;

    // Tick period and width in RUN
    wait_tick(n, 40);
    check("first_tick_seen", 8'(tick), 8'h01);
    wait_tick(n, 30);
    check("tick_period", 8'(n), 8'd10);
    check("tick_mode", 8'(mode), 8'h00);
    wait_tick(n, 30);
    check("tick_period2", 8'(n), 8'd10);

    // Pause with the prescaler frozen at 6
    cyc();
    check("tick_single", 8'(tick), 8'h00);
    cyc();
    cyc();
    time_stop = 1'b0;
    cyc();
    check("pause_lat1", 8'(mode), 8'h00);
    cyc();
    check("pause_lat2", 8'(mode), 8'h00);
    cyc();
    check("pause_mode", 8'(mode), 8'h01);
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      acc = acc | {5'd0, tick};
    end
    check("pause_no_tick", 8'(acc), 8'h00);
    check("pause_hold", 8'(mode), 8'h01);
    time_stop = 1'b1;
    cyc();
    cyc();
    check("resume_lat", 8'(mode), 8'h01);
    cyc();
    check("resume_mode", 8'(mode), 8'h00);
    wait_tick(n, 30);
    check("resume_tick_delay", 8'(n), 8'd4);

    // Set hours 14, minutes 37
    sw = 6'd14;
    set_pulse();
    check("set_hr_mode", 8'(mode), 8'h02);
    set_pulse();
    check("set_min_mode", 8'(mode), 8'h03);
    check("lh_pulse", 8'(lh), 8'h01);
    check("lh_tens", 8'(tens), 8'h01);
    check("lh_ones", 8'(ones), 8'h04);
    cyc();
    check("lh_single", 8'(lh), 8'h00);
    check("tens_hold", 8'(tens), 8'h01);
    check("ones_hold", 8'(ones), 8'h04);
    sw = 6'd37;
    set_pulse();
    check("exit_mode", 8'(mode), 8'h00);
    check("lm_pulse", 8'(lm), 8'h01);
    check("lm_tens", 8'(tens), 8'h03);
    check("lm_ones", 8'(ones), 8'h07);
    wait_tick(n, 30);
    check("tick_after_set", 8'(n), 8'd10);

    // Clamping
    sw = 6'd63;
    set_pulse();
    set_pulse();
    check("clamp_lh", 8'(lh), 8'h01);
    check("clamp_hr_tens", 8'(tens), 8'h02);
    check("clamp_hr_ones", 8'(ones), 8'h03);
    sw = 6'd60;
    set_pulse();
    check("clamp_lm", 8'(lm), 8'h01);
    check("clamp_min_tens", 8'(tens), 8'h05);
    check("clamp_min_ones", 8'(ones), 8'h09);
    sw = 6'd7;
    set_pulse();
    set_pulse();
    check("bcd7_tens", 8'(tens), 8'h00);
    check("bcd7_ones", 8'(ones), 8'h07);
    set_pulse();

    // Blink patterns
    set_pulse();
    check_blink("blink_hr", 6'b110000);
    check("blink_hr_mode", 8'(mode), 8'h02);
    set_pulse();
    check_blink("blink_min", 6'b001100);
    check("blink_min_mode", 8'(mode), 8'h03);
    set_pulse();
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      acc = acc | mask;
    end
    check("blink_run_off", 8'(acc), 8'h00);

    // Reset in the middle of SET_MIN
    set_pulse();
    set_pulse();
    cyc();
    check("pre_rst_mode", 8'(mode), 8'h03);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mode", 8'(mode), 8'h00);
    check("async_rst_lm", 8'(lm), 8'h00);
    check("async_rst_mask", 8'(mask), 8'h00);
    cyc();
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      acc = acc | {4'd0, lh, lm};
    end
    check("rst_no_strobe", 8'(acc), 8'h00);
    check("rst_recover_mode", 8'(mode), 8'h00);

    // Set edge and stop fall together; stop ignored while setting
    time_set  = 1'b1;
    time_stop = 1'b0;
    cyc();
    cyc();
    time_set = 1'b0;
    cyc();
    check("set_priority", 8'(mode), 8'h02);
    for (int i = 0; i < 5; i++) cyc();
    check("stop_ignored", 8'(mode), 8'h02);
    set_pulse();
    check("stop_ignored_min", 8'(mode), 8'h03);
    set_pulse();
    check("exit_to_run", 8'(mode), 8'h00);
    check("exit_lm", 8'(lm), 8'h01);
    cyc();
    check("exit_then_pause", 8'(mode), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
